trace_capture_fifo: RTL and testbench

//  Sits directly downstream of the single-cycle MIPS core, on its debug/writeback taps.

---
 rtl/trace_capture_fifo.sv | 171 +++++++++++++++++
 tb/tb_trace_capture_fifo.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_fifo.sv
// -----------------------------------------------------------------------------
// trace_capture_fifo
//
// Captures commit-time side effects of the single-cycle MIPS core (register-file
// writes and data-memory writes) as trace events, stamps each with its PC and a
// sequence number, and buffers them in a first-word-fall-through FIFO that a
// valid/ready consumer drains. The core is never back-pressured: when an event
// cannot be stored it is dropped and counted in drop_cnt_o.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   enable_i        1 = capture events from the taps; 0 = ignore taps
//   clear_i         synchronous flush of FIFO, sequence stamp and drop counter
//   pc_i            PC of the instruction committing this cycle
//   reg_write_i     register-file write strobe
//   write_reg_i     destination register number
//   write_data_i    value written to the register file
//   mem_write_i     data-memory write strobe
//   mem_addr_i      data-memory address
//   mem_wdata_i     data-memory write data
//   trace_valid_o   head entry is valid
//   trace_ready_i   consumer accepts the head entry
//   trace_kind_o    01 = REG, 10 = MEM, 00 when empty
//   trace_pc_o      PC of the head entry
//   trace_dest_o    REG: zero-extended register number; MEM: address
//   trace_data_o    register or memory write data of the head entry
//   trace_seq_o     sequence stamp of the head entry
//   count_o         current occupancy (0..DEPTH)
//   full_o          count_o == DEPTH
//   empty_o         count_o == 0
//   drop_cnt_o      events lost, saturating at all-ones
// -----------------------------------------------------------------------------
module trace_capture_fifo #(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       clear_i,
    input  logic [31:0]                pc_i,
    input  logic                       reg_write_i,
    input  logic [4:0]                 write_reg_i,
    input  logic [31:0]                write_data_i,
    input  logic                       mem_write_i,
    input  logic [31:0]                mem_addr_i,
    input  logic [31:0]                mem_wdata_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [1:0]                 trace_kind_o,
    output logic [31:0]                trace_pc_o,
    output logic [31:0]                trace_dest_o,
    output logic [31:0]                trace_data_o,
    output logic [SEQ_W-1:0]           trace_seq_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [SEQ_W-1:0]           drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] KIND_REG = 2'b01;
    localparam logic [1:0] KIND_MEM = 2'b10;

    // Add 0..2 to the drop counter, pinning at all-ones instead of wrapping.
    function automatic logic [SEQ_W-1:0] sat_add(input logic [SEQ_W-1:0] a,
                                                  input logic [1:0]       inc);
        logic [SEQ_W:0] sum;
        sum = {1'b0, a} + {{(SEQ_W-1){1'b0}}, inc};
        return sum[SEQ_W] ? {SEQ_W{1'b1}} : sum[SEQ_W-1:0];
    endfunction

    // Entry storage (data only, never reset; validity comes from count_q).
    logic [1:0]       mem_kind_q [DEPTH];
    logic [31:0]      mem_pc_q   [DEPTH];
    logic [31:0]      mem_dest_q [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [SEQ_W-1:0] mem_seq_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [SEQ_W-1:0] seq_q,    seq_d;
    logic [SEQ_W-1:0] drop_q,   drop_d;

    logic             mem_evt, reg_evt, any_evt, both_evt;
    logic             full, empty, pop, push;
    logic [1:0]       drop_inc;
    logic [1:0]       evt_kind;
    logic [31:0]      evt_dest, evt_data;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        mem_evt  = enable_i & mem_write_i;
        // Writes to $zero have no architectural effect and are never logged.
        reg_evt  = enable_i & reg_write_i & (write_reg_i != 5'd0);
        any_evt  = mem_evt | reg_evt;
        both_evt = mem_evt & reg_evt;

        // MEM wins a same-cycle collision; the REG event is the one lost.
        evt_kind = mem_evt ? KIND_MEM   : KIND_REG;
        evt_dest = mem_evt ? mem_addr_i : {27'b0, write_reg_i};
        evt_data = mem_evt ? mem_wdata_i : write_data_i;

        pop  = ~empty & trace_ready_i & ~clear_i;
        // A pop frees the slot in the same cycle, so a full FIFO still accepts.
        push = any_evt & (~full | pop) & ~clear_i;

        drop_inc = {1'b0, both_evt} + {1'b0, any_evt & ~push};

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        // Every detected event burns a stamp, pushed or not, so gaps expose losses.
        seq_d    = seq_q + SEQ_W'(mem_evt) + SEQ_W'(reg_evt);
        drop_d   = sat_add(drop_q, drop_inc);

        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            seq_d    = '0;
            drop_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
        end
    end

    // The stored stamp is the current seq_q: on a collision MEM takes seq_q and
    // the dropped REG takes seq_q+1.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_kind_q[wr_ptr_q] <= evt_kind;
            mem_pc_q[wr_ptr_q]   <= pc_i;
            mem_dest_q[wr_ptr_q] <= evt_dest;
            mem_data_q[wr_ptr_q] <= evt_data;
            mem_seq_q[wr_ptr_q]  <= seq_q;
        end
    end

    // Head entry falls through; fields are forced to zero while empty.
    assign trace_valid_o = ~empty;
    assign trace_kind_o  = empty ? '0 : mem_kind_q[rd_ptr_q];
    assign trace_pc_o    = empty ? '0 : mem_pc_q[rd_ptr_q];
    assign trace_dest_o  = empty ? '0 : mem_dest_q[rd_ptr_q];
    assign trace_data_o  = empty ? '0 : mem_data_q[rd_ptr_q];
    assign trace_seq_o   = empty ? '0 : mem_seq_q[rd_ptr_q];
    assign count_o       = count_q;
    assign full_o        = full;
    assign empty_o       = empty;
    assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_trace_capture_fifo.sv
module tb_trace_capture_fifo;

    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, clr, rw, mw, rdy;
    logic [4:0]  wreg;
    logic [31:0] pc, wdata, maddr, mwdata;

    logic        t_valid, t_full, t_empty;
    logic [1:0]  t_kind;
    logic [31:0] t_pc, t_dest, t_data;
    logic [15:0] t_seq, t_drop;
    logic [4:0]  t_count;

    int n_checks = 0;
    int n_fail   = 0;

    trace_capture_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
        .pc_i(pc), .reg_write_i(rw), .write_reg_i(wreg), .write_data_i(wdata),
        .mem_write_i(mw), .mem_addr_i(maddr), .mem_wdata_i(mwdata),
        .trace_valid_o(t_valid), .trace_ready_i(rdy), .trace_kind_o(t_kind),
        .trace_pc_o(t_pc), .trace_dest_o(t_dest), .trace_data_o(t_data),
        .trace_seq_o(t_seq), .count_o(t_count), .full_o(t_full),
        .empty_o(t_empty), .drop_cnt_o(t_drop)
    );

    always #5 clk = ~clk;

    wire [137:0] dut_vec = {t_valid, t_kind, t_pc, t_dest, t_data, t_seq,
                            t_count, t_full, t_empty, t_drop};

    // ---------------- reference model: a queue of committed events ----------
    typedef struct {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] dest;
        logic [31:0] data;
        logic [15:0] seq;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_seq  = 0;
    logic [15:0] m_drop = 0;

    task automatic model_reset();
        q.delete();
        m_seq  = 0;
        m_drop = 0;
    endtask

    task automatic model_drop();
        if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
    endtask

    always @(posedge clk) begin
        ent_t e;
        bit   have, do_pop;
        if (!rst_n || clr) begin
            model_reset();
        end else begin
            have   = 0;
            do_pop = (q.size() > 0) && rdy;
            e      = '{2'b00, 32'd0, 32'd0, 32'd0, 16'd0};
            if (en && mw) begin
                e = '{2'b10, pc, maddr, mwdata, m_seq};
                have = 1;
                m_seq = m_seq + 1;
            end
            if (en && rw && wreg != 0) begin
                if (have) model_drop();
                else begin
                    e = '{2'b01, pc, {27'd0, wreg}, wdata, m_seq};
                    have = 1;
                end
                m_seq = m_seq + 1;
            end
            if (do_pop) void'(q.pop_front());
            if (have) begin
                if (q.size() < DEPTH) q.push_back(e);
                else model_drop();
            end
        end
    end

    function automatic logic [137:0] exp_vec();
        ent_t h;
        logic v;
        h = '{2'b00, 32'd0, 32'd0, 32'd0, 16'd0};
        v = (q.size() > 0);
        if (v) h = q[0];
        return {v, h.kind, h.pc, h.dest, h.data, h.seq, 5'(q.size()),
                (q.size() == DEPTH), (q.size() == 0), m_drop};
    endfunction

    // ---------------- stimulus helpers ---------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1; clr = 0; rw = 0; mw = 0; rdy = 0;
        wreg = 0; pc = 0; wdata = 0; maddr = 0; mwdata = 0;
    endtask

    task automatic do_clear();
        idle();
        clr = 1;
        tick();
        clr = 0;
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        idle();
        rst_n = 0;
        #2;
        repeat (2) tick();
        n_checks++;
        if (t_valid !== 1'b0 || t_empty !== 1'b1 || t_full !== 1'b0 || t_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%b empty=%b full=%b count=%0d, want 0 1 0 0",
                     t_valid, t_empty, t_full, t_count);
        end
        n_checks++;
        if (t_kind !== 2'b00 || t_pc !== 0 || t_seq !== 0 || t_drop !== 0) begin
            n_fail++;
            $display("FAIL reset_fields: kind=%b pc=%h seq=%0d drop=%0d, want all 0",
                     t_kind, t_pc, t_seq, t_drop);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_reg_basic();
        idle();
        rw = 1; wreg = 5'd8; wdata = 32'h5; pc = 32'h4;
        tick();
        idle();
        n_checks++;
        if (t_valid !== 1 || t_kind !== 2'b01 || t_pc !== 32'h4 || t_dest !== 32'd8 ||
            t_data !== 32'h5 || t_seq !== 16'd0 || t_count !== 5'd1) begin
            n_fail++;
            $display("FAIL reg_basic: v=%b kind=%b pc=%h dest=%h data=%h seq=%0d cnt=%0d, want 1 01 4 8 5 0 1",
                     t_valid, t_kind, t_pc, t_dest, t_data, t_seq, t_count);
        end
        rdy = 1;
        tick();
        rdy = 0;
        n_checks++;
        if (t_empty !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reg_drain: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_zero_reg();
        idle();
        rw = 1; wreg = 5'd0; wdata = 32'hDEAD; pc = 32'h8;
        tick();
        idle();
        n_checks++;
        if (t_count !== 5'd0 || t_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg: count=%0d valid=%b, want 0 0", t_count, t_valid);
        end
        rw = 1; wreg = 5'd3; wdata = 32'h77; pc = 32'hC;
        tick();
        idle();
        n_checks++;
        if (t_seq !== 16'd1) begin
            n_fail++;
            $display("FAIL zero_reg_seq: seq=%0d want 1", t_seq);
        end
        rdy = 1;
        tick();
        idle();
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 18; i++) begin
            mw = 1; maddr = 32'h1000 + 4 * i; mwdata = $urandom; pc = 32'h400 + 4 * i;
            tick();
        end
        idle();
        n_checks++;
        if (t_full !== 1'b1 || t_count !== 5'd16 || t_drop !== 16'd2) begin
            n_fail++;
            $display("FAIL overflow: full=%b count=%0d drop=%0d, want 1 16 2", t_full, t_count, t_drop);
        end
        rdy = 1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (t_valid !== 1'b1 || t_seq !== 16'(i) || t_dest !== 32'h1000 + 4 * i ||
                dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: valid=%b seq=%0d dest=%h, want 1 %0d %h",
                         i, t_valid, t_seq, t_dest, i, 32'h1000 + 4 * i);
            end
            tick();
        end
        idle();
        n_checks++;
        if (t_empty !== 1'b1 || t_drop !== 16'd2) begin
            n_fail++;
            $display("FAIL drain_end: empty=%b drop=%0d, want 1 2", t_empty, t_drop);
        end
    endtask

    task automatic test_full_pushpop();
        do_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mw = 1; maddr = 32'h2000 + i; mwdata = i;
            tick();
        end
        mw = 1; rdy = 1; maddr = 32'h3000; mwdata = 32'hABCD;
        tick();
        idle();
        n_checks++;
        if (t_count !== 5'd16 || t_drop !== 16'd0 || t_seq !== 16'd1) begin
            n_fail++;
            $display("FAIL full_pushpop: count=%0d drop=%0d seq=%0d, want 16 0 1", t_count, t_drop, t_seq);
        end
        mw = 1; maddr = 32'h4000;
        tick();
        idle();
        n_checks++;
        if (t_drop !== 16'd1 || t_seq !== 16'd1 || t_dest !== 32'h2001 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_hold: drop=%0d seq=%0d dest=%h, want 1 1 2001", t_drop, t_seq, t_dest);
        end
    endtask

    task automatic test_both();
        do_clear();
        rw = 1; wreg = 5'd9; wdata = 32'h11; mw = 1; maddr = 32'h80; mwdata = 32'h22;
        tick();
        idle();
        n_checks++;
        if (t_count !== 5'd1 || t_kind !== 2'b10 || t_drop !== 16'd1 || t_seq !== 16'd0 ||
            t_data !== 32'h22) begin
            n_fail++;
            $display("FAIL both: count=%0d kind=%b drop=%0d seq=%0d data=%h, want 1 10 1 0 22",
                     t_count, t_kind, t_drop, t_seq, t_data);
        end
        rw = 1; wreg = 5'd9; wdata = 32'h33;
        tick();
        idle();
        rdy = 1;
        tick();
        idle();
        n_checks++;
        if (t_seq !== 16'd2 || t_kind !== 2'b01 || t_dest !== 32'd9) begin
            n_fail++;
            $display("FAIL both_seq_gap: seq=%0d kind=%b dest=%h, want 2 01 9", t_seq, t_kind, t_dest);
        end
        rdy = 1;
        tick();
        idle();
    endtask

    task automatic test_enable_clear();
        do_clear();
        en = 0; rw = 1; wreg = 5'd5; mw = 1;
        tick();
        idle();
        n_checks++;
        if (t_count !== 5'd0 || t_drop !== 16'd0) begin
            n_fail++;
            $display("FAIL enable_off: count=%0d drop=%0d, want 0 0", t_count, t_drop);
        end
        mw = 1; maddr = 32'h10;
        tick();
        mw = 1; maddr = 32'h14;
        tick();
        idle();
        n_checks++;
        if (t_seq !== 16'd0 || t_count !== 5'd2) begin
            n_fail++;
            $display("FAIL enable_seq: seq=%0d count=%0d, want 0 2", t_seq, t_count);
        end
        clr = 1; mw = 1; rdy = 1; rw = 1; wreg = 5'd2;
        tick();
        idle();
        n_checks++;
        if (t_count !== 5'd0 || t_valid !== 1'b0 || t_drop !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_prio: count=%0d valid=%b drop=%0d, want 0 0 0", t_count, t_valid, t_drop);
        end
        mw = 1; maddr = 32'h18;
        tick();
        idle();
        n_checks++;
        if (t_seq !== 16'd0 || t_count !== 5'd1) begin
            n_fail++;
            $display("FAIL clear_seq: seq=%0d count=%0d, want 0 1", t_seq, t_count);
        end
    endtask

    task automatic test_random();
        do_clear();
        for (int i = 0; i < 500; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            clr    = ($urandom_range(0, 63) == 0);
            rw     = $urandom_range(0, 1);
            wreg   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            wdata  = $urandom;
            mw     = ($urandom_range(0, 2) == 0);
            maddr  = $urandom;
            mwdata = $urandom;
            pc     = $urandom & 32'hFFFF_FFFC;
            rdy    = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int i = 0; i < 5; i++) begin
            mw = 1; maddr = 32'h500 + i; mwdata = i;
            tick();
        end
        idle();
        n_checks++;
        if (t_count !== 5'd5) begin
            n_fail++;
            $display("FAIL async_prefill: count=%0d want 5", t_count);
        end
        rdy = 1;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_checks++;
        if (t_valid !== 1'b0 || t_count !== 5'd0 || t_empty !== 1'b1 || t_pc !== 0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b count=%0d empty=%b pc=%h, want 0 0 1 0",
                     t_valid, t_count, t_empty, t_pc);
        end
        tick();
        rst_n = 1;
        idle();
        rw = 1; wreg = 5'd4; wdata = 32'h99;
        tick();
        idle();
        n_checks++;
        if (t_valid !== 1'b1 || t_seq !== 16'd0 || t_count !== 5'd1) begin
            n_fail++;
            $display("FAIL async_seq: valid=%b seq=%0d count=%0d, want 1 0 1", t_valid, t_seq, t_count);
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_reg_basic();
        test_zero_reg();
        test_overflow();
        test_full_pushpop();
        test_both();
        test_enable_clear();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
